// File: rtl/tt_um_asiclab_serial_sub_if.sv
// Pin bundle for the serial subtractor tile: operand/result buses and the
// bidirectional handshake pins. The master modport drives the tile inputs; the slave modport is the tile side.
interface tt_um_asiclab_serial_sub_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    modport master (
        output ui_in,
        output uio_in,
        output ena,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        input  ena,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_asiclab_serial_sub.sv
// Bit-serial nibble subtractor: latches A/B, computes A-B LSB-first over four
// cycles, then holds the result until ack. Macro SERIAL_SUB_SAT_EN selects saturate-to-zero on borrow.
module tt_um_asiclab_serial_sub (
    input  logic                            clk,
    input  logic                            rst_n,
    tt_um_asiclab_serial_sub_if.slave       io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] a_r, a_s;
    logic [3:0] b_r, b_s;
    logic [1:0] cnt_r, cnt_s;
    logic       br_r, br_s;
    logic [3:0] part_r, part_s;
    logic [5:0] res_r, res_s;
    logic       d_s;
    logic       br_nx_s;
    logic       start_s;
    logic       ack_s;
    logic       unused_s;

    function automatic logic borrow_out(input logic a0, input logic b0, input logic bin);
        borrow_out = (~a0 & b0) | (~(a0 ^ b0) & bin);
    endfunction

    // zero is taken from the difference actually presented, so saturation sets it too
    function automatic logic [5:0] pack_result(input logic [3:0] diff, input logic borrow);
        logic [3:0] shown;
`ifdef SERIAL_SUB_SAT_EN
        shown = borrow ? 4'h0 : diff;
`else
        shown = diff;
`endif
        pack_result = {(shown == 4'h0), borrow, shown};
    endfunction

    assign start_s  = io.uio_in[0];
    assign ack_s    = io.uio_in[1];
    assign d_s      = a_r[0] ^ b_r[0] ^ br_r;
    assign br_nx_s  = borrow_out(a_r[0], b_r[0], br_r);
    assign unused_s = ^{io.ena, io.uio_in[7:2]};

    // State, datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= 4'h0;
            b_r     <= 4'h0;
            cnt_r   <= 2'd0;
            br_r    <= 1'b0;
            part_r  <= 4'h0;
            res_r   <= 6'h00;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            cnt_r   <= cnt_s;
            br_r    <= br_s;
            part_r  <= part_s;
            res_r   <= res_s;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        cnt_s   = cnt_r;
        br_s    = br_r;
        part_s  = part_r;
        res_s   = res_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    a_s     = io.ui_in[7:4];
                    b_s     = io.ui_in[3:0];
                    br_s    = 1'b0;
                    cnt_s   = 2'd0;
                    part_s  = 4'h0;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                part_s = {d_s, part_r[3:1]};
                a_s    = {1'b0, a_r[3:1]};
                b_s    = {1'b0, b_r[3:1]};
                br_s   = br_nx_s;
                cnt_s  = cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    res_s   = pack_result({d_s, part_r[3:1]}, br_nx_s);
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (ack_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign io.uo_out  = {2'b00, res_r};
    assign io.uio_out = {4'b0000, (state_r == DONE), (state_r == SHIFT), 2'b00};
    assign io.uio_oe  = 8'b0000_1100;

endmodule
